// File: rtl/reg_clkdiv_multi_if.sv
// Byte-oriented register bus shared by the host and the clock-divider block.
// The master drives address/data/strobes; the slave returns read data and
// the hypothetical-length lookup.
interface reg_clkdiv_multi_if;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic        reg_stream;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_size, reg_read,
           reg_write, reg_addrvalid, reg_hypaddress,
    input  reg_datao, reg_stream, reg_hyplen
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_size, reg_read,
           reg_write, reg_addrvalid, reg_hypaddress,
    output reg_datao, reg_stream, reg_hyplen
  );
endinterface

// File: rtl/reg_clkdiv_multi.sv
// Multi-channel programmable clock divider behind a byte register bus.
// Each channel has shadow PERIOD/HIGH/PHASE fields; the active copies only
// reload at a period wrap, on enable, or on a global sync strobe, so a
// running waveform never changes shape mid-period.
module reg_clkdiv_multi #(
  parameter int         NCH       = 4,
  parameter int         CW        = 16,
  parameter logic [5:0] ADDR_CTRL = 6'd50,
  parameter logic [5:0] ADDR_EN   = 6'd51,
  parameter logic [5:0] ADDR_CFG  = 6'd52
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_clkdiv_multi_if.slave        bus,
  output logic [NCH-1:0]           divclk_o,
  output logic [NCH-1:0]           tick_o
);

  typedef logic [CW-1:0] field_t;

  // Bytes above CW are dropped on write and read back as zero.
  function automatic field_t set_byte(field_t old, logic hi, logic [7:0] d);
    logic [15:0] w;
    w = 16'(old);
    if (hi) w[15:8] = d;
    else    w[7:0]  = d;
    return w[CW-1:0];
  endfunction

  function automatic logic [7:0] get_byte(field_t f, logic hi);
    logic [15:0] w;
    w = 16'(f);
    return hi ? w[15:8] : w[7:0];
  endfunction

  field_t         period_q [NCH];
  field_t         high_q   [NCH];
  field_t         phase_q  [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic           sync_q;
  logic [7:0]     datao_q;

  logic [NCH-1:0] cfg_sel;
  logic           byte_ok;
  logic [1:0]     fsel;
  logic           bsel;
  logic           en_hit;
  logic [7:0]     rd_data;
  logic [15:0]    hyplen;

  assign byte_ok = bus.reg_bytecnt < 16'd6;
  assign fsel    = bus.reg_bytecnt[2:1];
  assign bsel    = bus.reg_bytecnt[0];
  assign en_hit  = (bus.reg_address == ADDR_EN) && (bus.reg_bytecnt == 16'd0);

  // Size and address-valid carry no meaning for this block.
  logic unused_bus;
  assign unused_bus = ^{bus.reg_size, bus.reg_addrvalid};

  // One-hot channel select for the CFG address window.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cfg_sel = '0;
    for (int n = 0; n < NCH; n++) begin
      if (bus.reg_address == ADDR_CFG + 6'(n)) cfg_sel[n] = 1'b1;
    end
  end

  // Next enable vector: a write to EN byte 0 replaces it, otherwise hold.
  always_comb begin
    en_d = en_q;
    if (bus.reg_write && en_hit) en_d = bus.reg_datai[NCH-1:0];
  end

  // Shadow fields, enables and the one-cycle sync strobe.
  // NOTE: register arrays are reset explicitly here because a cleared shadow is architecturally visible on readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        period_q[n] <= '0;
        high_q[n]   <= '0;
        phase_q[n]  <= '0;
      end
      en_q   <= '0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      en_q   <= en_d;
      sync_q <= bus.reg_write && (bus.reg_address == ADDR_CTRL) &&
                (bus.reg_bytecnt == 16'd0) && bus.reg_datai[0];
      for (int n = 0; n < NCH; n++) begin
        if (bus.reg_write && cfg_sel[n] && byte_ok) begin
          case (fsel)
            2'd0:    period_q[n] <= set_byte(period_q[n], bsel, bus.reg_datai);
            2'd1:    high_q[n]   <= set_byte(high_q[n],   bsel, bus.reg_datai);
            default: phase_q[n]  <= set_byte(phase_q[n],  bsel, bus.reg_datai);
          endcase
        end
      end
    end
  end

  // Read-data mux; CTRL and anything unmapped return zero.
  always_comb begin
    rd_data = 8'h00;
    if (en_hit) rd_data = 8'(en_q);
    for (int n = 0; n < NCH; n++) begin
      if (cfg_sel[n] && byte_ok) begin
        case (fsel)
          2'd0:    rd_data = get_byte(period_q[n], bsel);
          2'd1:    rd_data = get_byte(high_q[n],   bsel);
          default: rd_data = get_byte(phase_q[n],  bsel);
        endcase
      end
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             datao_q <= 8'h00;
    else if (bus.reg_read) datao_q <= rd_data;
  end

  // Register length lookup for the host's address probe.
  always_comb begin
    hyplen = 16'd0;
    if (bus.reg_hypaddress == ADDR_CTRL || bus.reg_hypaddress == ADDR_EN) hyplen = 16'd1;
    for (int n = 0; n < NCH; n++) begin
      if (bus.reg_hypaddress == ADDR_CFG + 6'(n)) hyplen = 16'd6;
    end
  end

  assign bus.reg_datao  = datao_q;
  assign bus.reg_stream = 1'b0;
  assign bus.reg_hyplen = hyplen;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    field_t cnt_q, act_period_q, act_high_q;
    logic   div_q, tick_q;
    field_t start_cnt;

    // A phase beyond the period would never be reached by the counter.
    assign start_cnt = (phase_q[n] < period_q[n]) ? phase_q[n] : period_q[n];

    // Counter with shadow reload at wrap/enable/sync and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q        <= '0;
        act_period_q <= '0;
        act_high_q   <= '0;
        div_q        <= 1'b0;
        tick_q       <= 1'b0;
      end else if (!en_d[n]) begin
        cnt_q  <= '0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!en_q[n]) begin
        act_period_q <= period_q[n];
        act_high_q   <= high_q[n];
        cnt_q        <= start_cnt;
        div_q        <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        div_q  <= cnt_q < act_high_q;
        tick_q <= cnt_q == act_period_q;
        if (sync_q) begin
          act_period_q <= period_q[n];
          act_high_q   <= high_q[n];
          cnt_q        <= start_cnt;
        end else if (cnt_q == act_period_q) begin
          act_period_q <= period_q[n];
          act_high_q   <= high_q[n];
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_q + field_t'(1);
        end
      end
    end

    assign divclk_o[n] = div_q;
    assign tick_o[n]   = tick_q;
  end

endmodule
